// File: rtl/my_112l_pkg.sv
// Shared types for the writeback stage: result-source and load-width encodings,
// FSM states, and the raw readdatasel decode.
package my_112l_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_PCJ = 2'd3
  } wb_src_t;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_sel_t;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_HI = 1'b1
  } wb_state_t;

  // Encodings 5-7 are reserved and behave as a full-word load.
  function automatic ld_sel_t toLdSel(input logic [2:0] raw);
    case (raw)
      3'd1:    return LD_B;
      3'd2:    return LD_BU;
      3'd3:    return LD_H;
      3'd4:    return LD_HU;
      default: return LD_W;
    endcase
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load extractor: shifts the addressed byte/halfword/word of a
// two-word window down to bit 0 and sign- or zero-extends it.
module wb_load_align
  import my_112l_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] word_i,
  input  logic [1:0]          off_i,
  input  ld_sel_t             sel_i,
  output logic [DATA_W-1:0]   data_o
);

  logic [DATA_W-1:0] window;

  assign window = DATA_W'(word_i >> {off_i, 3'b000});

  always_comb begin
    case (sel_i)
      LD_B:    data_o = {{(DATA_W-8){window[7]}}, window[7:0]};
      LD_BU:   data_o = {{(DATA_W-8){1'b0}}, window[7:0]};
      LD_H:    data_o = {{(DATA_W-16){window[15]}}, window[15:0]};
      LD_HU:   data_o = {{(DATA_W-16){1'b0}}, window[15:0]};
      default: data_o = window;
    endcase
  end

endmodule

// File: rtl/wb_stage_reg.sv
// Registered writeback stage with retire counter. Define WB_MISALIGN_EN to merge
// word-spanning loads over two beats; otherwise such loads raise misalign_err.
module wb_stage_reg
  import my_112l_pkg::*;
#(
  parameter int PC_W       = 9,
  parameter int DATA_W     = 32,
  parameter int RF_ADDRESS = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  flush,
  input  logic [PC_W-1:0]       PCPlus4,
  input  logic [PC_W-1:0]       PCJump,
  input  logic [DATA_W-1:0]     readdata,
  input  logic [DATA_W-1:0]     ALUResult,
  input  logic [1:0]            memtoreg,
  input  logic [2:0]            readdatasel,
  input  logic                  regwrite,
  input  logic [RF_ADDRESS-1:0] rd,
  output logic                  rf_we,
  output logic [RF_ADDRESS-1:0] rf_rd,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  busy,
  output logic                  misalign_err,
  output logic [CNT_W-1:0]      retire_cnt
);

  logic                  accept;
  logic                  misalign;
  ld_sel_t               selIn;
  logic [2*DATA_W-1:0]   alignWord;
  logic [1:0]            alignOff;
  ld_sel_t               alignSel;
  logic [DATA_W-1:0]     alignData;
  logic [DATA_W-1:0]     srcData;

  logic                  complete;
  logic                  rfWe_d, rfWe_q;
  logic [RF_ADDRESS-1:0] rfRd_d, rfRd_q;
  logic [DATA_W-1:0]     rfWdata_d, rfWdata_q;
  logic                  err_d, err_q;
  logic [CNT_W-1:0]      cnt_q;

`ifdef WB_MISALIGN_EN
  wb_state_t             state_d, state_q;
  logic                  capture;
  logic [RF_ADDRESS-1:0] rdHold_q;
  logic                  rwHold_q;
  ld_sel_t               selHold_q;
  logic [1:0]            offHold_q;
  logic [DATA_W-1:0]     lo_q;
`endif

  assign accept = in_valid && !flush;
  assign selIn  = toLdSel(readdatasel);
  assign misalign = (wb_src_t'(memtoreg) == WB_MEM) &&
                    (((selIn == LD_W) && (ALUResult[1:0] != 2'd0)) ||
                     (((selIn == LD_H) || (selIn == LD_HU)) && (ALUResult[1:0] == 2'd3)));

  // While merging, the extractor sees the held low word under the new high word.
  always_comb begin
    alignWord = {{DATA_W{1'b0}}, readdata};
    alignOff  = ALUResult[1:0];
    alignSel  = selIn;
`ifdef WB_MISALIGN_EN
    if (state_q == WAIT_HI) begin
      alignWord = {readdata, lo_q};
      alignOff  = offHold_q;
      alignSel  = selHold_q;
    end
`endif
  end

  wb_load_align #(.DATA_W(DATA_W)) u_align (
    .word_i (alignWord),
    .off_i  (alignOff),
    .sel_i  (alignSel),
    .data_o (alignData)
  );

  always_comb begin
    case (wb_src_t'(memtoreg))
      WB_MEM:  srcData = alignData;
      WB_PC4:  srcData = {{(DATA_W-PC_W){1'b0}}, PCPlus4};
      WB_PCJ:  srcData = {{(DATA_W-PC_W){1'b0}}, PCJump};
      default: srcData = ALUResult;
    endcase
  end

  always_comb begin
    complete  = 1'b0;
    rfWe_d    = 1'b0;
    rfRd_d    = rd;
    rfWdata_d = srcData;
    err_d     = 1'b0;
`ifdef WB_MISALIGN_EN
    state_d = state_q;
    capture = 1'b0;
    if (state_q == WAIT_HI) begin
      rfRd_d    = rdHold_q;
      rfWdata_d = alignData;
      if (flush) begin
        state_d = IDLE;
      end else if (in_valid) begin
        complete = 1'b1;
        rfWe_d   = rwHold_q && (rdHold_q != '0);
        state_d  = IDLE;
      end
    end else if (accept) begin
      if (misalign) begin
        capture = 1'b1;
        state_d = WAIT_HI;
      end else begin
        complete = 1'b1;
        rfWe_d   = regwrite && (rd != '0);
      end
    end
`else
    if (accept) begin
      if (misalign) begin
        err_d = 1'b1;
      end else begin
        complete = 1'b1;
        rfWe_d   = regwrite && (rd != '0);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rfWe_q    <= 1'b0;
      rfRd_q    <= '0;
      rfWdata_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rfWe_q <= rfWe_d;
      err_q  <= err_d;
      if (complete) begin
        rfRd_q    <= rfRd_d;
        rfWdata_q <= rfWdata_d;
        cnt_q     <= cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef WB_MISALIGN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rdHold_q  <= '0;
      rwHold_q  <= 1'b0;
      selHold_q <= LD_W;
      offHold_q <= '0;
      lo_q      <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        rdHold_q  <= rd;
        rwHold_q  <= regwrite;
        selHold_q <= selIn;
        offHold_q <= ALUResult[1:0];
        lo_q      <= readdata;
      end
    end
  end

  assign busy = (state_q == WAIT_HI);
`else
  assign busy = 1'b0;
`endif

  assign rf_we        = rfWe_q;
  assign rf_rd        = rfRd_q;
  assign rf_wdata     = rfWdata_q;
  assign misalign_err = err_q;
  assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Scoreboard bench for wb_stage_reg: expected writes are queued when the
// completing beat is driven and popped one cycle later against the DUT outputs.
module tb_wb_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        flush;
  logic [8:0]  PCPlus4;
  logic [8:0]  PCJump;
  logic [31:0] readdata;
  logic [31:0] ALUResult;
  logic [1:0]  memtoreg;
  logic [2:0]  readdatasel;
  logic        regwrite;
  logic [4:0]  rd;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        misalign_err;
  logic [31:0] retire_cnt;

  wb_stage_reg #(.PC_W(9), .DATA_W(32), .RF_ADDRESS(5), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .flush        (flush),
    .PCPlus4      (PCPlus4),
    .PCJump       (PCJump),
    .readdata     (readdata),
    .ALUResult    (ALUResult),
    .memtoreg     (memtoreg),
    .readdatasel  (readdatasel),
    .regwrite     (regwrite),
    .rd           (rd),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
    .busy         (busy),
    .misalign_err (misalign_err),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic [1:0]  m2r;
    logic [2:0]  sel;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        rw;
    logic [4:0]  rdv;
    logic [31:0] want;
  } vec_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] expCnt = '0;

  // Reference extraction built byte by byte from the two-word window.
  function automatic logic [31:0] refLoad(input logic [63:0] w, input logic [1:0] off,
                                          input logic [2:0] sel);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[8*k +: 8] = w[8*(int'(off)+k) +: 8];
    case (sel)
      3'd1:    return {{24{v[7]}}, v[7:0]};
      3'd2:    return {24'h0, v[7:0]};
      3'd3:    return {{16{v[15]}}, v[15:0]};
      3'd4:    return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] refValue(input logic [1:0] m2r, input logic [2:0] sel,
                                           input logic [31:0] alu, input logic [31:0] rdata);
    case (m2r)
      2'd0:    return alu;
      2'd1:    return refLoad({32'h0, rdata}, alu[1:0], sel);
      2'd2:    return {23'h0, PCPlus4};
      default: return {23'h0, PCJump};
    endcase
  endfunction

  task automatic setBeat(input logic [1:0] m2r, input logic [2:0] sel, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic rw, input logic [4:0] rdv);
    in_valid    = 1'b1;
    flush       = 1'b0;
    memtoreg    = m2r;
    readdatasel = sel;
    ALUResult   = alu;
    readdata    = rdata;
    regwrite    = rw;
    rd          = rdv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic expectWrite(input logic rw, input logic [4:0] rdv, input logic [31:0] data);
    exp_t e;
    expCnt = expCnt + 32'd1;
    e.we = rw && (rdv != 5'd0);
    e.rd = rdv;
    e.data = data;
    e.cnt = expCnt;
    sb.push_back(e);
  endtask

  task automatic popExp(output exp_t e);
    if (sb.size() == 0) begin
      e.we = 1'bx; e.rd = 'x; e.data = 'x; e.cnt = 'x;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; PCPlus4 = '0; PCJump = '0;
    readdata = '0; ALUResult = '0; memtoreg = '0; readdatasel = '0; regwrite = 1'b0; rd = '0;
    #12;
    tests++;
    if ({rf_we, rf_rd, rf_wdata, busy, misalign_err, retire_cnt} !== 71'h0) begin
      fails++;
      $display("[TB] FAIL reset_state: got we=%0b rd=%0d data=%h busy=%0b err=%0b cnt=%0d want all 0",
               rf_we, rf_rd, rf_wdata, busy, misalign_err, retire_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_alu();
    exp_t e;
    setBeat(2'd0, 3'd0, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1, 5'd5);
    expectWrite(1'b1, 5'd5, 32'h0000_1234);
    tick();
    popExp(e);
    tests++;
    if ({rf_we, rf_rd, rf_wdata, retire_cnt} !== {e.we, e.rd, e.data, e.cnt} || e.cnt !== 32'd1) begin
      fails++;
      $display("[TB] FAIL alu_path: got we=%0b rd=%0d data=%h cnt=%0d want we=%0b rd=%0d data=%h cnt=1",
               rf_we, rf_rd, rf_wdata, retire_cnt, e.we, e.rd, e.data);
    end
    tick();
    tests++;
    if (rf_we !== 1'b0 || retire_cnt !== expCnt) begin
      fails++;
      $display("[TB] FAIL we_one_cycle: got we=%0b cnt=%0d want we=0 cnt=%0d", rf_we, retire_cnt, expCnt);
    end
  endtask

  task automatic test_loads();
    vec_t v[$];
    exp_t e;
    PCPlus4 = 9'h1F4;
    PCJump  = 9'h0A8;
    v.push_back('{2'd1, 3'd1, 32'h0000_0103, 32'h80AA_BBCC, 1'b1, 5'd6,  32'hFFFF_FF80});
    v.push_back('{2'd1, 3'd2, 32'h0000_0103, 32'h80AA_BBCC, 1'b1, 5'd7,  32'h0000_0080});
    v.push_back('{2'd1, 3'd3, 32'h0000_0102, 32'h80AA_BBCC, 1'b1, 5'd8,  32'hFFFF_80AA});
    v.push_back('{2'd1, 3'd4, 32'h0000_0101, 32'h80AA_BBCC, 1'b1, 5'd9,  32'h0000_AABB});
    v.push_back('{2'd1, 3'd0, 32'h0000_0200, 32'hCAFE_F00D, 1'b1, 5'd10, 32'hCAFE_F00D});
    v.push_back('{2'd1, 3'd1, 32'h0000_0000, 32'h1234_567F, 1'b1, 5'd11, 32'h0000_007F});
    v.push_back('{2'd1, 3'd5, 32'h0000_0040, 32'h89AB_CDEF, 1'b1, 5'd12, 32'h89AB_CDEF});
    v.push_back('{2'd1, 3'd3, 32'h0000_0000, 32'h0000_8001, 1'b1, 5'd13, 32'hFFFF_8001});
    v.push_back('{2'd2, 3'd0, 32'h0000_0000, 32'h0000_0000, 1'b1, 5'd14, 32'h0000_01F4});
    v.push_back('{2'd3, 3'd0, 32'h0000_0000, 32'h0000_0000, 1'b1, 5'd15, 32'h0000_00A8});
    v.push_back('{2'd0, 3'd0, 32'hFFFF_0000, 32'h0000_0000, 1'b0, 5'd16, 32'hFFFF_0000});
    v.push_back('{2'd0, 3'd0, 32'h0000_0055, 32'h0000_0000, 1'b1, 5'd0,  32'h0000_0055});
    foreach (v[i]) begin
      setBeat(v[i].m2r, v[i].sel, v[i].alu, v[i].rdata, v[i].rw, v[i].rdv);
      expectWrite(v[i].rw, v[i].rdv, v[i].want);
      tick();
      popExp(e);
      tests++;
      if ({rf_we, rf_rd, rf_wdata, retire_cnt} !== {e.we, e.rd, e.data, e.cnt}) begin
        fails++;
        $display("[TB] FAIL load_vec%0d: got we=%0b rd=%0d data=%h cnt=%0d want we=%0b rd=%0d data=%h cnt=%0d",
                 i, rf_we, rf_rd, rf_wdata, retire_cnt, e.we, e.rd, e.data, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  m2r;
    logic [2:0]  sel;
    logic [31:0] alu;
    logic [31:0] rdata;
    exp_t        e;
    for (int i = 0; i < 10; i++) begin
      m2r   = 2'($urandom_range(0, 3));
      sel   = 3'($urandom_range(0, 7));
      alu   = $urandom;
      rdata = $urandom;
      PCPlus4 = 9'($urandom);
      PCJump  = 9'($urandom);
      if (m2r == 2'd1 && (sel == 3'd0 || sel > 3'd4)) alu[1:0] = 2'd0;
      if (m2r == 2'd1 && (sel == 3'd3 || sel == 3'd4) && alu[1:0] == 2'd3) alu[1:0] = 2'd2;
      setBeat(m2r, sel, alu, rdata, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      expectWrite(regwrite, rd, refValue(m2r, sel, alu, rdata));
      tick();
      popExp(e);
      tests++;
      if ({rf_we, rf_rd, rf_wdata, retire_cnt} !== {e.we, e.rd, e.data, e.cnt}) begin
        fails++;
        $display("[TB] FAIL b2b_%0d: got we=%0b rd=%0d data=%h cnt=%0d want we=%0b rd=%0d data=%h cnt=%0d",
                 i, rf_we, rf_rd, rf_wdata, retire_cnt, e.we, e.rd, e.data, e.cnt);
      end
    end
  endtask

  task automatic test_flush_idle();
    setBeat(2'd0, 3'd0, 32'h0000_7777, 32'h0, 1'b1, 5'd20);
    flush = 1'b1;
    tick();
    tests++;
    if (rf_we !== 1'b0 || retire_cnt !== expCnt || rf_rd === 5'd20) begin
      fails++;
      $display("[TB] FAIL flush_idle: got we=%0b rd=%0d cnt=%0d want we=0 rd!=20 cnt=%0d",
               rf_we, rf_rd, retire_cnt, expCnt);
    end
  endtask

`ifdef WB_MISALIGN_EN
  task automatic test_merge();
    exp_t e;
    setBeat(2'd1, 3'd0, 32'h0000_0302, 32'h1122_3344, 1'b1, 5'd9);
    tick();
    tests++;
    if (busy !== 1'b1 || rf_we !== 1'b0) begin
      fails++;
      $display("[TB] FAIL merge_busy: got busy=%0b we=%0b want busy=1 we=0", busy, rf_we);
    end
    tick();
    tests++;
    if (busy !== 1'b1 || rf_we !== 1'b0 || retire_cnt !== expCnt) begin
      fails++;
      $display("[TB] FAIL merge_hold: got busy=%0b we=%0b cnt=%0d want busy=1 we=0 cnt=%0d",
               busy, rf_we, retire_cnt, expCnt);
    end
    setBeat(2'd0, 3'd1, 32'hFFFF_FFFF, 32'h5566_7788, 1'b0, 5'd3);
    expectWrite(1'b1, 5'd9, 32'h7788_1122);
    tick();
    popExp(e);
    tests++;
    if ({rf_we, rf_rd, rf_wdata, retire_cnt, busy} !== {e.we, e.rd, e.data, e.cnt, 1'b0}) begin
      fails++;
      $display("[TB] FAIL merge_lw: got we=%0b rd=%0d data=%h cnt=%0d busy=%0b want we=%0b rd=%0d data=%h cnt=%0d busy=0",
               rf_we, rf_rd, rf_wdata, retire_cnt, busy, e.we, e.rd, e.data, e.cnt);
    end
    for (int s = 3; s <= 4; s++) begin
      setBeat(2'd1, 3'(s), 32'h0000_0007, 32'h8000_0000, 1'b1, 5'(9 + s));
      tick();
      setBeat(2'd0, 3'd0, 32'h0, 32'h0000_00FF, 1'b0, 5'd0);
      expectWrite(1'b1, 5'(9 + s), refLoad(64'h0000_00FF_8000_0000, 2'd3, 3'(s)));
      tick();
      popExp(e);
      tests++;
      if ({rf_we, rf_rd, rf_wdata, retire_cnt} !== {e.we, e.rd, e.data, e.cnt}) begin
        fails++;
        $display("[TB] FAIL merge_half_sel%0d: got we=%0b rd=%0d data=%h cnt=%0d want we=%0b rd=%0d data=%h cnt=%0d",
                 s, rf_we, rf_rd, rf_wdata, retire_cnt, e.we, e.rd, e.data, e.cnt);
      end
    end
    setBeat(2'd1, 3'd0, 32'h0000_0001, 32'hAAAA_AAAA, 1'b1, 5'd14);
    tick();
    setBeat(2'd0, 3'd0, 32'h0, 32'hBBBB_BBBB, 1'b1, 5'd14);
    flush = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || rf_we !== 1'b0 || retire_cnt !== expCnt) begin
      fails++;
      $display("[TB] FAIL flush_wait_hi: got busy=%0b we=%0b cnt=%0d want busy=0 we=0 cnt=%0d",
               busy, rf_we, retire_cnt, expCnt);
    end
    tick();
    tests++;
    if (rf_we !== 1'b0 || retire_cnt !== expCnt) begin
      fails++;
      $display("[TB] FAIL flush_no_late_write: got we=%0b cnt=%0d want we=0 cnt=%0d", rf_we, retire_cnt, expCnt);
    end
  endtask
`else
  task automatic test_misalign_err();
    exp_t e;
    setBeat(2'd1, 3'd0, 32'h0000_0302, 32'h1122_3344, 1'b1, 5'd9);
    tick();
    tests++;
    if (misalign_err !== 1'b1 || rf_we !== 1'b0 || busy !== 1'b0 || retire_cnt !== expCnt) begin
      fails++;
      $display("[TB] FAIL misalign_lw: got err=%0b we=%0b busy=%0b cnt=%0d want err=1 we=0 busy=0 cnt=%0d",
               misalign_err, rf_we, busy, retire_cnt, expCnt);
    end
    tick();
    tests++;
    if (misalign_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL misalign_pulse: got err=%0b want 0", misalign_err);
    end
    setBeat(2'd1, 3'd4, 32'h0000_0003, 32'h8000_0000, 1'b1, 5'd12);
    tick();
    tests++;
    if (misalign_err !== 1'b1 || rf_we !== 1'b0 || retire_cnt !== expCnt) begin
      fails++;
      $display("[TB] FAIL misalign_lhu3: got err=%0b we=%0b cnt=%0d want err=1 we=0 cnt=%0d",
               misalign_err, rf_we, retire_cnt, expCnt);
    end
    setBeat(2'd1, 3'd3, 32'h0000_0002, 32'h8001_0000, 1'b1, 5'd13);
    expectWrite(1'b1, 5'd13, 32'hFFFF_8001);
    tick();
    popExp(e);
    tests++;
    if ({misalign_err, rf_we, rf_rd, rf_wdata, retire_cnt} !== {1'b0, e.we, e.rd, e.data, e.cnt}) begin
      fails++;
      $display("[TB] FAIL lh_off2_ok: got err=%0b we=%0b rd=%0d data=%h cnt=%0d want err=0 we=%0b rd=%0d data=%h cnt=%0d",
               misalign_err, rf_we, rf_rd, rf_wdata, retire_cnt, e.we, e.rd, e.data, e.cnt);
    end
  endtask
`endif

  task automatic test_async_reset();
    exp_t e;
`ifdef WB_MISALIGN_EN
    setBeat(2'd1, 3'd0, 32'h0000_0001, 32'h1234_5678, 1'b1, 5'd17);
`else
    setBeat(2'd0, 3'd0, 32'h0000_4321, 32'h0, 1'b1, 5'd17);
    expectWrite(1'b1, 5'd17, 32'h0000_4321);
`endif
    tick();
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({rf_we, rf_rd, rf_wdata, busy, misalign_err, retire_cnt} !== 71'h0) begin
      fails++;
      $display("[TB] FAIL async_reset: got we=%0b rd=%0d data=%h busy=%0b err=%0b cnt=%0d want all 0",
               rf_we, rf_rd, rf_wdata, busy, misalign_err, retire_cnt);
    end
    sb.delete();
    expCnt = '0;
    @(negedge clk);
    reset = 1'b0;
    setBeat(2'd1, 3'd0, 32'h0000_0010, 32'h0BAD_CAFE, 1'b1, 5'd4);
    expectWrite(1'b1, 5'd4, 32'h0BAD_CAFE);
    tick();
    popExp(e);
    tests++;
    if ({rf_we, rf_rd, rf_wdata, retire_cnt, busy} !== {e.we, e.rd, e.data, e.cnt, 1'b0}) begin
      fails++;
      $display("[TB] FAIL after_reset_lw: got we=%0b rd=%0d data=%h cnt=%0d busy=%0b want we=%0b rd=%0d data=%h cnt=%0d busy=0",
               rf_we, rf_rd, rf_wdata, retire_cnt, busy, e.we, e.rd, e.data, e.cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_back_to_back();
    test_flush_idle();
`ifdef WB_MISALIGN_EN
    test_merge();
`else
    test_misalign_err();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
